// File: rtl/ft600_sched_pkg.sv
// Shared types for the FT600 245-sync bus scheduler.
package ft600_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_OE,
    RX_BURST,
    TX_PRE,
    TX_BURST,
    TX_DRAIN,
    TURN
  } sched_state_t;

  typedef enum logic {
    DIR_RX,
    DIR_TX
  } dir_t;

endpackage

// File: rtl/ft600_bus_scheduler.sv
// Arbitrates the shared FT600 16-bit bus between host->FPGA and FPGA->host bursts,
// generating the FT600 strobes, the data drive enable and the loopback FIFO enables.
module ft600_bus_scheduler
  import ft600_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned MAX_BURST   = 256,
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             ftdi_clk,
  input  logic             rst,
  input  logic             ftdi_rxf_n,
  input  logic             ftdi_txe_n,
  input  logic [CNT_W-1:0] fifo_count,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             ftdi_oe_n,
  output logic             ftdi_rd_n,
  output logic             ftdi_wr_n,
  output logic             data_drive_en,
  output logic             fifo_w_en,
  output logic             fifo_r_en,
  output logic             busy,
  output logic [31:0]      rx_word_cnt,
  output logic [31:0]      tx_word_cnt
);

  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam int unsigned TURN_W  = $clog2(TURN_CYCLES + 1);

  localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0]   FILL_GUARD = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [TURN_W-1:0]  TURN_LAST  = TURN_W'(TURN_CYCLES - 1);

  sched_state_t       state_q, state_d;
  dir_t               last_dir_q, last_dir_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [TURN_W-1:0]  turn_q, turn_d;
  logic               oe_n_q, rd_n_q, wr_n_q, drive_q, busy_q;
  logic [31:0]        rx_cnt_q, tx_cnt_q;
  logic               rx_ok, tx_ok;
  logic               w_en, r_en;

  assign rx_ok = !ftdi_rxf_n && !fifo_full;
  assign tx_ok = !ftdi_txe_n && !fifo_empty;

  // Next-state, burst/turnaround counting and the combinational FIFO enables.
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    burst_d    = burst_q;
    turn_d     = turn_q;
    w_en       = 1'b0;
    r_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_ok && (!tx_ok || last_dir_q == DIR_TX)) begin
          state_d = RX_OE;
        end else if (tx_ok) begin
          state_d = TX_PRE;
        end
      end
      RX_OE: begin
        burst_d = '0;
        state_d = RX_BURST;
      end
      RX_BURST: begin
        w_en = !ftdi_rxf_n && !fifo_full;
        if (w_en && burst_q != BURST_MAX) begin
          burst_d = burst_q + BURST_W'(1);
        end
        // Stopping at DEPTH-1 leaves room for the word sampled on this same cycle.
        if (ftdi_rxf_n || (w_en && burst_q == BURST_LAST) || fifo_count >= FILL_GUARD) begin
          state_d    = TURN;
          turn_d     = '0;
          last_dir_d = DIR_RX;
        end
      end
      TX_PRE: begin
        burst_d = '0;
        state_d = TX_BURST;
      end
      TX_BURST: begin
        r_en = !ftdi_txe_n && !fifo_empty && (burst_q < BURST_MAX);
        if (r_en) begin
          burst_d = burst_q + BURST_W'(1);
        end
        if (ftdi_txe_n || fifo_empty || burst_q == BURST_MAX) begin
          state_d = TX_DRAIN;
        end
      end
      TX_DRAIN: begin
        state_d    = TURN;
        turn_d     = '0;
        last_dir_d = DIR_TX;
      end
      TURN: begin
        if (turn_q == TURN_LAST) begin
          state_d = IDLE;
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state; WR_N lags the pop by the FIFO read latency.
  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_dir_q <= DIR_TX;
      burst_q    <= '0;
      turn_q     <= '0;
      oe_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      drive_q    <= 1'b0;
      busy_q     <= 1'b0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      burst_q    <= burst_d;
      turn_q     <= turn_d;
      oe_n_q     <= !(state_d == RX_OE || state_d == RX_BURST);
      rd_n_q     <= (state_d != RX_BURST);
      wr_n_q     <= !r_en;
      drive_q    <= (state_d == TX_PRE || state_d == TX_BURST || state_d == TX_DRAIN);
      busy_q     <= (state_d != IDLE);
      rx_cnt_q   <= rx_cnt_q + 32'(w_en);
      tx_cnt_q   <= tx_cnt_q + 32'(r_en);
    end
  end

  assign ftdi_oe_n     = oe_n_q;
  assign ftdi_rd_n     = rd_n_q;
  assign ftdi_wr_n     = wr_n_q;
  assign data_drive_en = drive_q;
  assign fifo_w_en     = w_en;
  assign fifo_r_en     = r_en;
  assign busy          = busy_q;
  assign rx_word_cnt   = rx_cnt_q;
  assign tx_word_cnt   = tx_cnt_q;

endmodule

// File: tb/tb_ft600_bus_scheduler.sv
// Self-checking bench for ft600_bus_scheduler: directed phases plus random RXF/TXE
// traffic, checked each cycle against bus-ownership rules and a FIFO occupancy model.
module tb_ft600_bus_scheduler;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned MAXB  = 16;
  localparam int unsigned TURN  = 2;
  localparam int unsigned CW    = 7;

  logic          clk = 1'b0;
  logic          rst, rxf_n, txe_n;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          oe_n, rd_n, wr_n, drive_en, w_en, r_en, busy;
  logic [31:0]   rx_cnt, tx_cnt;

  always #5 clk = ~clk;

  ft600_bus_scheduler #(
    .FIFO_DEPTH(DEPTH), .MAX_BURST(MAXB), .TURN_CYCLES(TURN), .CNT_W(CW)
  ) dut (
    .ftdi_clk(clk), .rst(rst), .ftdi_rxf_n(rxf_n), .ftdi_txe_n(txe_n),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .ftdi_oe_n(oe_n), .ftdi_rd_n(rd_n), .ftdi_wr_n(wr_n), .data_drive_en(drive_en),
    .fifo_w_en(w_en), .fifo_r_en(r_en), .busy(busy),
    .rx_word_cnt(rx_cnt), .tx_word_cnt(tx_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Environment and reference state (owner: 0 none, 1 RX, 2 TX)
  int   fifo_lvl = 0;
  int   exp_rx = 0, exp_tx = 0;
  logic prev_r_en = 1'b0;
  int   prev_owner = 0, gap = 100, last_served = 2;
  logic prev_oe_n = 1'b1, prev_rd_n = 1'b1;
  logic prev_rx_ok = 1'b0, prev_tx_ok = 1'b0;
  int   burst_words = 0, own_start = 0, first_ren_off = -1, starts = 0;
  int   cyc = 0, n_w = 0, n_r = 0, n_wr = 0;
  int   burst_q[$];
  logic s_busy = 1'b0, s_w = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive FIFO status, check the cycle, then advance the models.
  task automatic tick();
    int   own, expd;
    logic w, r, in_rst;
    fifo_count = CW'(fifo_lvl);
    fifo_full  = (fifo_lvl >= int'(DEPTH));
    fifo_empty = (fifo_lvl == 0);
    #1;
    w = (w_en === 1'b1);
    r = (r_en === 1'b1);
    in_rst = rst;
    s_busy = busy;
    s_w    = w;
    if (!in_rst) begin
      own = !oe_n ? 1 : (drive_en ? 2 : 0);
      check("inv_drive_oe", 32'(drive_en & !oe_n), 0);
      check("inv_wen_ren", 32'(w & r), 0);
      check("wen_legal", 32'(w & !(!rd_n & !rxf_n & !fifo_full)), 0);
      check("ren_legal", 32'(r & !(drive_en & !txe_n & !fifo_empty)), 0);
      check("wr_n_lag", 32'(wr_n), 32'(!prev_r_en));
      check("wr_n_owner", 32'(!wr_n & !drive_en), 0);
      check("rx_word_cnt", rx_cnt, 32'(exp_rx));
      check("tx_word_cnt", tx_cnt, 32'(exp_tx));
      check("rd_needs_oe", 32'(!rd_n & !(!oe_n & !prev_oe_n)), 0);
      check("busy_idle", 32'(!busy & ((own != 0) | w | r | !wr_n)), 0);
      if (!rd_n && prev_rd_n) check("rd_one_after_oe", 32'(cyc - own_start), 1);
      if (own != 0 && prev_owner != 0) check("no_direct_swap", 32'(own), 32'(prev_owner));
      if (own != 0 && prev_owner == 0) begin
        check("turn_gap", 32'(gap >= int'(TURN) + 1), 1);
        if (prev_rx_ok && prev_tx_ok) expd = (last_served == 1) ? 2 : 1;
        else if (prev_rx_ok)          expd = 1;
        else if (prev_tx_ok)          expd = 2;
        else                          expd = 0;
        check("rr_dir", 32'(own), 32'(expd));
        last_served = own;
        burst_words = 0;
        own_start = cyc;
        first_ren_off = -1;
        starts++;
      end
      if (own != 0) burst_words += int'(w | r);
      if (r && own == 2 && first_ren_off < 0) first_ren_off = cyc - own_start;
      if (own == 0 && prev_owner != 0) begin
        check("burst_len_max", 32'(burst_words <= int'(MAXB)), 1);
        burst_q.push_back(burst_words);
      end
      gap = (own == 0) ? gap + 1 : 0;
      prev_owner = own;
      prev_oe_n = oe_n;
      prev_rd_n = rd_n;
      prev_rx_ok = !rxf_n && !fifo_full;
      prev_tx_ok = !txe_n && !fifo_empty;
      n_wr += int'(!wr_n);
    end
    n_w += int'(w);
    n_r += int'(r);
    @(posedge clk);
    fifo_lvl = fifo_lvl + int'(w) - int'(r);
    if (in_rst) begin
      exp_rx = 0; exp_tx = 0; prev_r_en = 1'b0;
      prev_owner = 0; prev_oe_n = 1'b1; prev_rd_n = 1'b1;
      gap = 100; last_served = 2;
    end else begin
      exp_rx += int'(w);
      exp_tx += int'(r);
      prev_r_en = r;
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input int limit);
    run(4);
    for (int i = 0; i < limit && s_busy; i++) tick();
    check("idle_timeout", 32'(s_busy), 0);
  endtask

  initial begin
    int n, w0, r0, wr0, nb;
    rst = 1'b1; rxf_n = 1'b1; txe_n = 1'b1;
    fifo_count = '0; fifo_full = 1'b0; fifo_empty = 1'b1;

    // Reset
    run(2);
    rst = 1'b0;
    check("rst_oe_n", 32'(oe_n), 1);
    check("rst_rd_n", 32'(rd_n), 1);
    check("rst_wr_n", 32'(wr_n), 1);
    check("rst_drive", 32'(drive_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rx_cnt", rx_cnt, 0);
    check("rst_tx_cnt", tx_cnt, 0);

    // RX burst of exactly 8 words ended by RXF_N
    rxf_n = 1'b0;
    n = 0;
    for (int i = 0; i < 60 && n < 8; i++) begin
      tick();
      if (s_w) n++;
    end
    rxf_n = 1'b1;
    check("rx8_words", 32'(n), 8);
    wait_idle(40);
    check("rx8_total", rx_cnt, 8);
    check("rx8_fifo_lvl", 32'(fifo_lvl), 8);

    // TX burst draining the 8 words
    r0 = n_r; wr0 = n_wr;
    txe_n = 1'b0;
    wait_idle(60);
    txe_n = 1'b1;
    check("tx8_pops", 32'(n_r - r0), 8);
    check("tx8_wr_strobes", 32'(n_wr - wr0), 8);
    check("tx8_total", tx_cnt, 8);
    check("tx_pre_one_cycle", 32'(first_ren_off), 1);
    check("tx8_drive_off", 32'(drive_en), 0);
    check("tx8_fifo_lvl", 32'(fifo_lvl), 0);

    // Both directions requesting: round-robin alternation
    nb = starts;
    rxf_n = 1'b0; txe_n = 1'b0;
    run(200);
    rxf_n = 1'b1; txe_n = 1'b1;
    wait_idle(60);
    check("rr_burst_count", 32'(starts - nb >= 4), 1);

    // Fill guard: count 60 gives exactly 4 words, no overflow
    fifo_lvl = 60;
    w0 = n_w;
    rxf_n = 1'b0;
    wait_idle(60);
    check("guard_words", 32'(n_w - w0), 4);
    check("guard_lvl", 32'(fifo_lvl), 64);
    check("guard_full", 32'(fifo_full), 1);
    rxf_n = 1'b1;

    // Burst limit with ample space
    fifo_lvl = 0;
    nb = burst_q.size();
    rxf_n = 1'b0;
    for (int i = 0; i < 200 && burst_q.size() < nb + 2; i++) tick();
    rxf_n = 1'b1;
    check("maxb_bursts_seen", 32'(burst_q.size() >= nb + 2), 1);
    if (burst_q.size() >= nb + 2) begin
      check("maxb_len_a", 32'(burst_q[nb]), 32'(MAXB));
      check("maxb_len_b", 32'(burst_q[nb + 1]), 32'(MAXB));
    end
    wait_idle(60);

    // Reset in the middle of a TX burst
    fifo_lvl = 20;
    r0 = n_r;
    txe_n = 1'b0;
    for (int i = 0; i < 40 && (n_r - r0) < 3; i++) tick();
    check("midtx_started", 32'(n_r - r0), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_wr_n", 32'(wr_n), 1);
    check("midrst_drive", 32'(drive_en), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_r_en", 32'(r_en), 0);
    check("midrst_tx_cnt", tx_cnt, 0);
    txe_n = 1'b1;
    wait_idle(60);

    // Random RXF/TXE traffic
    for (int i = 0; i < 3000; i++) begin
      rxf_n = ($urandom_range(0, 9) < 3);
      txe_n = ($urandom_range(0, 9) < 3);
      tick();
    end
    rxf_n = 1'b1; txe_n = 1'b1;
    wait_idle(60);
    check("final_rx_cnt", rx_cnt, 32'(exp_rx));
    check("final_tx_cnt", tx_cnt, 32'(exp_tx));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
